// File: rtl/fir_mac_sequencer.sv
`default_nettype none
//== fir_mac_sequencer -- sequential FIR filter, one multiplier time-shared across all taps ==
//== Revision 1.0 ==
module fir_mac_sequencer #(
  parameter int TAPS       = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DATA_FRAC  = 15,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 15,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_FRAC  = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovr,
  input  logic                         coef_we,
  input  logic [$clog2(TAPS)-1:0]      coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wdata,
  output logic                         coef_ready,
  input  logic                         clr,
  output logic                         busy
);

  localparam int KW = $clog2(TAPS);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam int AW = PW + KW;
  localparam int SH = DATA_FRAC + COEF_FRAC - DOUT_FRAC;
  localparam logic [KW-1:0] KMAX = KW'(TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_CONV, S_OUT} state_t;

  state_t                        state_q, state_d;
  logic [KW-1:0]                 k_q, k_d;
  logic signed [AW-1:0]          acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  x_q [TAPS];
  logic signed [DATA_WIDTH-1:0]  x_d [TAPS];
  logic signed [COEF_WIDTH-1:0]  w_q [TAPS];
  logic signed [COEF_WIDTH-1:0]  w_d [TAPS];
  logic signed [DOUT_WIDTH-1:0]  dout_q, dout_d;
  logic                          ovr_q, ovr_d;

  logic signed [PW-1:0]          prod;
  logic [31:0]                   addr_ext;
  logic [AW-1:SH+DOUT_WIDTH-1]   acc_hi;

  assign prod     = x_q[k_q] * w_q[k_q];
  assign addr_ext = 32'(coef_addr);
  // Bits above dout plus dout's own MSB: all equal means the value fits.
  assign acc_hi   = acc_q[AW-1:SH+DOUT_WIDTH-1];

  assign in_ready   = rst_n && (state_q == S_IDLE);
  assign coef_ready = rst_n && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign dout       = dout_q;
  assign ovr        = ovr_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    x_d     = x_q;
    w_d     = w_q;
    dout_d  = dout_q;
    ovr_d   = ovr_q;

    if (coef_we && (state_q == S_IDLE) && (addr_ext < 32'(TAPS))) begin
      w_d[coef_addr] = coef_wdata;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
          x_d[0]  = din;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{KW{prod[PW-1]}}, prod};
        if (k_q == KMAX) begin
          k_d     = '0;
          state_d = S_CONV;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_CONV: begin
        dout_d  = acc_q[SH +: DOUT_WIDTH];
        ovr_d   = !((&acc_hi) || (~|acc_hi));
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over accept and completion; coefficients survive it.
    if (clr) begin
      state_d = S_IDLE;
      k_d     = '0;
      acc_d   = '0;
      for (int i = 0; i < TAPS; i++) x_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      ovr_q   <= ovr_d;
      x_q     <= x_d;
      w_q     <= w_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter TAPS, default 8: number of filter taps, at least 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of input samples, signed.
REQ-003 SHALL have parameter DATA_FRAC, default 15: fractional bits of input samples.
REQ-004 SHALL have parameter COEF_WIDTH, default 16: width of coefficients, signed.
REQ-005 SHALL have parameter COEF_FRAC, default 15: fractional bits of coefficients.
REQ-006 SHALL have parameter DOUT_WIDTH, default 16: width of the output, signed.
REQ-007 SHALL have parameter DOUT_FRAC, default 15: fractional bits of the output; DOUT_FRAC <= DATA_FRAC+COEF_FRAC.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1) and din (input, DATA_WIDTH): the sample handshake.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), dout (output, DOUT_WIDTH) and ovr (output, 1): the result handshake and overflow flag.
REQ-012 SHALL have ports coef_we (input, 1), coef_addr (input, $clog2(TAPS)) and coef_wdata (input, COEF_WIDTH): the coefficient write port.
REQ-013 SHALL have port coef_ready (output, 1): a coefficient write is accepted this cycle.
REQ-014 SHALL have ports clr (input, 1), a synchronous flush, and busy (output, 1), high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> MAC -> CONV -> OUT -> IDLE using exactly one multiplier, time-shared across taps.
REQ-016 IDLE: in_ready=1 and coef_ready=1; in every other state both SHALL be 0.
REQ-017 Sample accept (IDLE, in_valid=1): shift the delay line x[k] <= x[k-1], load x[0] <= din, clear acc, set k=0, go to MAC.
REQ-018 MAC: each cycle acc += x[k]*w[k] (full-precision signed product), then k++; after k=TAPS-1, go to CONV.
REQ-019 acc width SHALL be DATA_WIDTH+COEF_WIDTH+$clog2(TAPS), with DATA_FRAC+COEF_FRAC fractional bits, and SHALL never wrap.
REQ-020 CONV: drop the (DATA_FRAC+COEF_FRAC-DOUT_FRAC) LSBs of acc (truncation, i.e. rounding toward minus infinity), keep the next DOUT_WIDTH bits and register them to dout.
REQ-021 CONV: register ovr=1 when the discarded upper acc bits are not all equal to dout's MSB; dout then holds the wrapped value.
REQ-022 out_valid SHALL rise exactly TAPS+1 clock edges after the accepting edge; dout and ovr are valid only while out_valid=1.
REQ-023 OUT: out_valid=1; dout and ovr SHALL be held stable until out_ready=1, then the FSM goes to IDLE with out_valid=0 on the next cycle.
REQ-024 Coefficient write (coef_we=1 and coef_ready=1): w[coef_addr] <= coef_wdata; a write with coef_addr >= TAPS SHALL be ignored.
REQ-025 coef_we while coef_ready=0 SHALL be ignored, not queued.
REQ-026 A coefficient write and a sample accept in the same IDLE cycle SHALL both occur, and the new coefficient SHALL be used for that sample.
REQ-027 clr=1 in any state SHALL, at the next edge, zero the delay line and acc, go to IDLE and drive out_valid=0, keeping coefficients.
REQ-028 clr SHALL take priority over a sample accept and over the out_ready completion in the same cycle.
REQ-029 The first TAPS-1 outputs after reset or clr SHALL treat the missing history as zero.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, k=0, acc=0, delay line=0, all coefficients=0, dout=0, ovr=0, out_valid=0.
REQ-031 During reset, in_ready=0, coef_ready=0 and busy=0; after release, in_ready and coef_ready SHALL rise in the first cycle.
REQ-032 Reset asserted during MAC, CONV or OUT SHALL abort with no output produced.

Verification (TAPS=4, all formats Q1.15)
REQ-033 Impulse: w={0x4000,0x2000,0x1000,0x0800}, samples 0x4000,0,0,0,0 -> dout 0x2000,0x1000,0x0800,0x0400,0x0000; ovr=0 throughout; out_valid rises 5 edges after each accept.
REQ-034 Truncation: w[0]=0x4000 and others 0, sample 0xFFFF -> dout=0xFFFF, ovr=0.
REQ-035 Overflow: all w=0x7FFF, four samples 0x7FFF -> the fourth output has ovr=1, and dout equals the wrapped truncated sum.
REQ-036 Backpressure: out_ready=0 for 5 cycles in OUT -> out_valid, dout and ovr stay stable and in_ready=0; the first out_ready=1 leads to IDLE.
REQ-037 Busy write: coef_we to addr 1 during MAC -> coef_ready=0 and w[1] unchanged (checked by an impulse).
REQ-038 Abort: clr during MAC, and separately rst_n low during OUT -> next cycle IDLE with out_valid=0; the next impulse reproduces REQ-033 from zero history.
